// File: rtl/lsu_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_pkg : funct3 codes, FSM states and request checks for lsu    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
package lsu_pkg;

  localparam int ADDR_W = 12;
  localparam int XLEN   = 64;

  typedef enum logic [2:0] {
    LD_B  = 3'b000,
    LD_H  = 3'b001,
    LD_W  = 3'b010,
    LD_D  = 3'b011,
    LD_BU = 3'b100,
    LD_HU = 3'b101,
    LD_WU = 3'b110
  } load_f3_e;

  typedef enum logic [2:0] {
    ST_B = 3'b000,
    ST_H = 3'b001,
    ST_W = 3'b010,
    ST_D = 3'b011
  } store_f3_e;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_RMW_RD = 3'd2,
    S_WRITE  = 3'd3,
    S_RESP   = 3'd4
  } state_e;

  function automatic logic req_legal(input logic we, input logic [2:0] f3);
    logic ok;
    ok = we ? !f3[2] : (f3 != 3'b111);
    return ok;
  endfunction

  // Size is encoded in funct3[1:0] for both loads and stores.
  function automatic logic req_misaligned(input logic [2:0] f3, input logic [2:0] lane);
    logic bad;
    case (f3[1:0])
      2'b00:   bad = 1'b0;
      2'b01:   bad = lane[0];
      2'b10:   bad = |lane[1:0];
      default: bad = |lane;
    endcase
    return bad;
  endfunction

endpackage
`default_nettype wire

// File: rtl/lsu_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_if : core request/response and data-memory bus of the LSU    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
interface lsu_if #(
  parameter int ADDR_W = lsu_pkg::ADDR_W,
  parameter int XLEN   = lsu_pkg::XLEN
);
  import lsu_pkg::*;

  logic              req_valid;
  logic              req_ready;
  logic              req_we;
  logic [2:0]        req_funct3;
  logic [ADDR_W-1:0] req_addr;
  logic [XLEN-1:0]   req_wdata;
  logic              resp_valid;
  logic [XLEN-1:0]   resp_rdata;
  logic              resp_err;
  logic              mem_read_en;
  logic              mem_write_en;
  logic [ADDR_W-1:0] mem_addr;
  logic [XLEN-1:0]   mem_wdata;
  logic [XLEN-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
           mem_read_en, mem_write_en, mem_addr, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, mem_rdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
           mem_read_en, mem_write_en, mem_addr, mem_wdata
  );

endinterface
`default_nettype wire

// File: rtl/lsu_lane.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu_lane : load lane extract/extend and sub-doubleword merge     |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsu_lane #(
  parameter int XLEN = lsu_pkg::XLEN
) (
  input  logic [2:0]      funct3,
  input  logic [2:0]      lane,
  input  logic [XLEN-1:0] rdata,
  input  logic [XLEN-1:0] wdata,
  output logic [XLEN-1:0] load_data,
  output logic [XLEN-1:0] store_data
);
  import lsu_pkg::*;

  localparam int NB = XLEN / 8;

  logic [XLEN-1:0] shifted;
  logic [XLEN-1:0] wdata_sh;
  logic [XLEN-1:0] bit_mask;
  logic [NB-1:0]   size_mask;
  logic [NB-1:0]   byte_mask;

  assign shifted  = rdata >> {lane, 3'b000};
  assign wdata_sh = wdata << {lane, 3'b000};

  always_comb begin
    load_data = shifted;
    case (funct3)
      LD_B:    load_data = {{(XLEN-8){shifted[7]}}, shifted[7:0]};
      LD_H:    load_data = {{(XLEN-16){shifted[15]}}, shifted[15:0]};
      LD_W:    load_data = {{(XLEN-32){shifted[31]}}, shifted[31:0]};
      LD_BU:   load_data = {{(XLEN-8){1'b0}}, shifted[7:0]};
      LD_HU:   load_data = {{(XLEN-16){1'b0}}, shifted[15:0]};
      LD_WU:   load_data = {{(XLEN-32){1'b0}}, shifted[31:0]};
      default: load_data = shifted;
    endcase
  end

  always_comb begin
    size_mask = '1;
    case (funct3[1:0])
      2'b00:   size_mask = NB'(1);
      2'b01:   size_mask = NB'(3);
      2'b10:   size_mask = NB'(15);
      default: size_mask = '1;
    endcase
  end

  assign byte_mask = size_mask << lane;

  for (genvar b = 0; b < NB; b++) begin : g_byte
    assign bit_mask[8*b +: 8] = {8{byte_mask[b]}};
  end

  assign store_data = (rdata & ~bit_mask) | (wdata_sh & bit_mask);

endmodule
`default_nettype wire

// File: rtl/lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | lsu : single-outstanding load/store unit with store read-merge   |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module lsu #(
  parameter int ADDR_W = lsu_pkg::ADDR_W,
  parameter int XLEN   = lsu_pkg::XLEN
) (
  input  logic clk,
  input  logic rst_n,
  lsu_if.slave bus
);
  import lsu_pkg::*;

  state_e            state_q, state_d;
  logic [2:0]        funct3_q, funct3_d;
  logic [2:0]        lane_q, lane_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [XLEN-1:0]   mem_wdata_q, mem_wdata_d;
  logic [XLEN-1:0]   rdata_q, rdata_d;
  logic              err_q, err_d;
  logic              req_ready_q, req_ready_d;
  logic              mem_read_en_q, mem_read_en_d;
  logic              mem_write_en_q, mem_write_en_d;
  logic              resp_valid_q, resp_valid_d;

  logic [XLEN-1:0]   load_data;
  logic [XLEN-1:0]   merge_data;
  logic              req_bad;

  assign req_bad = !req_legal(bus.req_we, bus.req_funct3)
                 || req_misaligned(bus.req_funct3, bus.req_addr[2:0]);

  lsu_lane #(.XLEN(XLEN)) u_lane (
    .funct3     (funct3_q),
    .lane       (lane_q),
    .rdata      (bus.mem_rdata),
    .wdata      (wdata_q),
    .load_data  (load_data),
    .store_data (merge_data)
  );

  always_comb begin
    state_d     = state_q;
    funct3_d    = funct3_q;
    lane_d      = lane_q;
    wdata_d     = wdata_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    rdata_d     = rdata_q;
    err_d       = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          funct3_d   = bus.req_funct3;
          lane_d     = bus.req_addr[2:0];
          wdata_d    = bus.req_wdata;
          mem_addr_d = {bus.req_addr[ADDR_W-1:3], 3'b000};
          rdata_d    = '0;
          if (req_bad) begin
            err_d   = 1'b1;
            state_d = S_RESP;
          end else if (!bus.req_we) begin
            state_d = S_LOAD;
          end else if (bus.req_funct3[1:0] == 2'b11) begin
            mem_wdata_d = bus.req_wdata;
            state_d     = S_WRITE;
          end else begin
            state_d = S_RMW_RD;
          end
        end
      end
      S_LOAD: begin
        rdata_d = load_data;
        state_d = S_RESP;
      end
      S_RMW_RD: begin
        mem_wdata_d = merge_data;
        state_d     = S_WRITE;
      end
      S_WRITE: state_d = S_RESP;
      S_RESP: begin
        rdata_d = '0;
        err_d   = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Strobes are decoded from the next state so they are flops aligned with it.
    req_ready_d    = (state_d == S_IDLE);
    mem_read_en_d  = (state_d == S_LOAD) || (state_d == S_RMW_RD);
    mem_write_en_d = (state_d == S_WRITE);
    resp_valid_d   = (state_d == S_RESP);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      funct3_q       <= '0;
      lane_q         <= '0;
      wdata_q        <= '0;
      mem_addr_q     <= '0;
      mem_wdata_q    <= '0;
      rdata_q        <= '0;
      err_q          <= 1'b0;
      req_ready_q    <= 1'b1;
      mem_read_en_q  <= 1'b0;
      mem_write_en_q <= 1'b0;
      resp_valid_q   <= 1'b0;
    end else begin
      state_q        <= state_d;
      funct3_q       <= funct3_d;
      lane_q         <= lane_d;
      wdata_q        <= wdata_d;
      mem_addr_q     <= mem_addr_d;
      mem_wdata_q    <= mem_wdata_d;
      rdata_q        <= rdata_d;
      err_q          <= err_d;
      req_ready_q    <= req_ready_d;
      mem_read_en_q  <= mem_read_en_d;
      mem_write_en_q <= mem_write_en_d;
      resp_valid_q   <= resp_valid_d;
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.resp_valid   = resp_valid_q;
  assign bus.resp_rdata   = rdata_q;
  assign bus.resp_err     = err_q;
  assign bus.mem_read_en  = mem_read_en_q;
  assign bus.mem_write_en = mem_write_en_q;
  assign bus.mem_addr     = mem_addr_q;
  assign bus.mem_wdata    = mem_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_lsu.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_lsu : directed scoreboard bench for lsu with a byte memory    |
// | rev 1.0                                                          |
// +------------------------------------------------------------------+
module tb_lsu;
  import lsu_pkg::*;

  typedef struct {
    logic [63:0] rdata;
    logic        err;
    int          lat;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  lsu_if #(.ADDR_W(12), .XLEN(64)) bus ();

  lsu #(.ADDR_W(12), .XLEN(64)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t       sb[$];
  int         pass_cnt = 0;
  int         total    = 0;
  int         cyc      = 0;
  int         resp_cnt = 0;
  int         rd_cnt   = 0;
  int         wr_cnt   = 0;
  int         wr_cyc   = -1;
  bit         both_seen = 1'b0;
  logic [7:0] mem [0:4095];
  bit         loaded = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: zero fill plus the 0x010..0x017 pattern on the first edge.
  always @(posedge clk) begin
    if (!loaded) begin
      for (int i = 0; i < 4096; i++) mem[i] <= 8'h00;
      for (int i = 0; i < 8; i++) mem[16 + i] <= 8'(8'h11 * (i + 1));
      loaded <= 1'b1;
    end else if (bus.mem_write_en) begin
      for (int i = 0; i < 8; i++)
        mem[{bus.mem_addr[11:3], 3'(i)}] <= bus.mem_wdata[8*i +: 8];
    end
  end

  always_comb begin
    bus.mem_rdata = '0;
    for (int i = 0; i < 8; i++)
      bus.mem_rdata[8*i +: 8] = mem[{bus.mem_addr[11:3], 3'(i)}];
  end

  always @(negedge clk) begin
    if (bus.resp_valid) resp_cnt++;
    if (bus.mem_read_en) rd_cnt++;
    if (bus.mem_write_en) begin
      wr_cnt++;
      wr_cyc = cyc;
    end
    if (bus.mem_read_en && bus.mem_write_en) both_seen = 1'b1;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  task automatic issue(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                       input logic [63:0] wd, output int acc);
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = addr;
    bus.req_wdata  = wd;
    chk("req_ready_idle", bus.req_ready, 1);
    acc = cyc + 1;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_resp(input int acc);
    exp_t e;
    bit   got;
    got = 1'b0;
    for (int i = 0; i < 10 && !got; i++) begin
      @(negedge clk);
      if (bus.resp_valid) got = 1'b1;
    end
    chk("resp_seen", got, 1);
    if (got && sb.size() > 0) begin
      e = sb.pop_front();
      chk("resp_rdata", bus.resp_rdata, e.rdata);
      chk("resp_err", bus.resp_err, e.err);
      chk("resp_latency", cyc - acc + 1, e.lat);
    end
  endtask

  task automatic req(input logic we, input logic [2:0] f3, input logic [11:0] addr,
                     input logic [63:0] wd, input logic [63:0] exp_rd, input logic exp_err,
                     input int exp_lat, output int acc);
    sb.push_back('{rdata: exp_rd, err: exp_err, lat: exp_lat});
    issue(we, f3, addr, wd, acc);
    wait_resp(acc);
    @(negedge clk);
    chk("resp_pulse_end", bus.resp_valid, 0);
  endtask

  initial begin
    int acc, acc0, acc1, w0, r0, e0;
    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;

    repeat (3) @(negedge clk);
    chk("rst_req_ready", bus.req_ready, 1);
    chk("rst_resp_valid", bus.resp_valid, 0);
    chk("rst_rd_en", bus.mem_read_en, 0);
    chk("rst_wr_en", bus.mem_write_en, 0);
    chk("rst_rdata", bus.resp_rdata, 0);
    chk("rst_err", bus.resp_err, 0);
    rst_n = 1'b1;

    req(0, LD_B,  12'h017, 0, 64'hFFFF_FFFF_FFFF_FF88, 0, 2, acc);
    req(0, LD_BU, 12'h017, 0, 64'h0000_0000_0000_0088, 0, 2, acc);
    req(0, LD_D,  12'h010, 0, 64'h8877_6655_4433_2211, 0, 2, acc);

    w0 = wr_cnt;
    req(1, ST_H, 12'h012, 64'hABCD, 0, 0, 3, acc);
    chk("sh_write_once", wr_cnt - w0, 1);
    chk("sh_write_cycle", wr_cyc - acc, 1);
    req(0, LD_D, 12'h010, 0, 64'h8877_6655_ABCD_2211, 0, 2, acc);

    req(1, ST_B, 12'h011, 64'h7E, 0, 0, 3, acc);
    req(0, LD_D,  12'h010, 0, 64'h8877_6655_ABCD_7E11, 0, 2, acc);
    req(0, LD_W,  12'h014, 0, 64'hFFFF_FFFF_8877_6655, 0, 2, acc);
    req(0, LD_HU, 12'h016, 0, 64'h0000_0000_0000_8877, 0, 2, acc);
    req(0, LD_H,  12'h016, 0, 64'hFFFF_FFFF_FFFF_8877, 0, 2, acc);
    req(1, ST_W, 12'h01C, 64'h1234_5678_DEAD_BEEF, 0, 0, 3, acc);
    req(0, LD_D, 12'h018, 0, 64'hDEAD_BEEF_0000_0000, 0, 2, acc);

    e0 = rd_cnt + wr_cnt;
    req(0, LD_W,  12'h013, 0, 0, 1, 1, acc);
    req(0, 3'b111, 12'h000, 0, 0, 1, 1, acc);
    req(1, 3'b100, 12'h020, 64'h5A, 0, 1, 1, acc);
    req(1, ST_H,  12'h021, 64'h5A, 0, 1, 1, acc);
    req(0, LD_D,  12'h004, 0, 0, 1, 1, acc);
    chk("err_no_mem_access", rd_cnt + wr_cnt - e0, 0);

    req(1, ST_D,  12'hFF8, 64'h0123_4567_89AB_CDEF, 0, 0, 2, acc);
    req(0, LD_D,  12'hFF8, 0, 64'h0123_4567_89AB_CDEF, 0, 2, acc);
    req(0, LD_WU, 12'hFFC, 0, 64'h0000_0000_0123_4567, 0, 2, acc);
    req(0, LD_H,  12'hFFE, 0, 64'h0000_0000_0000_0123, 0, 2, acc);
    req(0, LD_B,  12'hFF8, 0, 64'hFFFF_FFFF_FFFF_FFEF, 0, 2, acc);

    // Abort a byte store while it is in its read phase.
    w0 = wr_cnt;
    r0 = resp_cnt;
    issue(1, ST_B, 12'h020, 64'h5A, acc);
    rst_n = 1'b0;
    @(negedge clk);
    chk("abort_req_ready", bus.req_ready, 1);
    chk("abort_rd_en", bus.mem_read_en, 0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("abort_no_write", wr_cnt - w0, 0);
    chk("abort_no_resp", resp_cnt - r0, 0);
    chk("abort_mem_kept", mem[32], 8'h00);
    chk("abort_ready_after", bus.req_ready, 1);

    r0 = resp_cnt;
    sb.push_back('{rdata: 64'h8877_6655_ABCD_7E11, err: 1'b0, lat: 2});
    sb.push_back('{rdata: 64'hDEAD_BEEF_0000_0000, err: 1'b0, lat: 2});
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = LD_D;
    bus.req_addr   = 12'h010;
    chk("b2b_ready_first", bus.req_ready, 1);
    acc0 = cyc + 1;
    @(negedge clk);
    chk("b2b_ready_load", bus.req_ready, 0);
    bus.req_addr = 12'h018;
    wait_resp(acc0);
    chk("b2b_ready_resp", bus.req_ready, 0);
    @(negedge clk);
    chk("b2b_ready_idle", bus.req_ready, 1);
    acc1 = cyc + 1;
    chk("b2b_spacing", acc1 - acc0, 3);
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    wait_resp(acc1);
    repeat (3) @(negedge clk);
    chk("b2b_resp_count", resp_cnt - r0, 2);

    chk("no_rd_wr_overlap", both_seen, 0);
    chk("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
